bsg_link_flit_tx: RTL and testbench
===================================

# bsg_link_flit_tx

Single-clock, credit-based transmit endpoint for the link layer. Accepts 64-bit core words through a valid/ready handshake and serializes each word into `channel_width_p`-bit flits, least-significant first. Flits are sent only against credits returned by the far-end receiver as token pulses. It sits between a core-side producer and a narrow link channel, and mirrors the receiver's buffer depth through its credit counter.

## Interface
- `width_p`, 64, core word width; must be an integer multiple of `channel_width_p`.
- `channel_width_p`, 16, flit width; ratio R = `width_p`/`channel_width_p` (4 by default).
- `credit_max_p`, 16, receiver buffer depth in words; initial and maximum credit count.
- `lg_credit_decimation_p`, 2, each token pulse returns 2^`lg_credit_decimation_p` credits (4).

Ports:
- `core_clk_i`  in  1  sole clock; all state on its rising edge.
- `core_link_reset_i`  in  1  asynchronous, active-high reset.
- `core_data_i`  in  `width_p`  word to send.
- `core_valid_i`  in  1  word valid.
- `core_ready_o`  out  1  block can accept a word this cycle.
- `link_data_o`  out  `channel_width_p`  current flit.
- `link_valid_o`  out  1  flit valid.
- `link_parity_o`  out  1  even parity of `link_data_o` (see Configuration).
- `token_i`  in  1  credit-return pulse, one per cycle high.
- `credit_count_o`  out  `$clog2(credit_max_p+1)`  current credits.
- `error_o`  out  1  sticky credit-overflow flag.

## Operation
- FSM states: IDLE and SEND. A flit counter 0..R-1 runs in SEND. A word register holds the accepted word.
- Accept occurs when `core_valid_i` && `core_ready_o`.
- `core_ready_o` = (IDLE || (SEND && cnt==R-1)) && `credit_count_o` != 0.
  - It depends only on registered state, never on `core_valid_i` or `token_i`.
- On accept:
  - Load the word register, set cnt=0, and enter or stay in SEND.
  - Decrement credits by 1.
- In SEND:
  - `link_valid_o`=1 and `link_data_o` = word[cnt*channel_width_p +: channel_width_p].
  - cnt increments each cycle.
  - At cnt==R-1 with no accept, return to IDLE.
- In IDLE: `link_valid_o`=0 and `link_data_o`=0.
- Credit update: next = current − accept + (`token_i` ? 2^lg : 0).
  - Accept and token in the same cycle apply together.
- Overflow: if next > `credit_max_p`, saturate at `credit_max_p` and set `error_o`. `error_o` clears only on reset.
- Underflow cannot occur, because accept requires credits != 0.

## Timing
- Reset values:
  - State IDLE, cnt 0.
  - `link_valid_o` 0, `link_data_o` 0, `link_parity_o` 0.
  - `credit_count_o` = `credit_max_p`, `error_o` 0.
  - `core_ready_o` 1.
- Latency: a word accepted in cycle t drives flit k in cycle t+1+k, for k=0..R-1.
- Throughput: back-to-back accepts every R cycles produce gap-free `link_valid_o`.
- A token in cycle t is visible in `credit_count_o` and `core_ready_o` at t+1.
- Reset asserted mid-word:
  - `link_valid_o` drops immediately (asynchronously) and the partial word is discarded.
  - Credits are restored to `credit_max_p`; the receiver is reset in the same domain.
- All outputs are driven from registers or from logic on registers only. There are no input-to-output combinational paths.

## Configuration
- `BSG_LINK_FLIT_TX_PARITY_EN` defined: `link_parity_o` = XOR-reduce(`link_data_o`) when `link_valid_o`, otherwise 0.
- Not defined: `link_parity_o` is tied to 0 and no parity logic is built.

## Structure
- Package `bsg_link_flit_pkg`:
  - FSM state enum typedef (IDLE, SEND).
  - Default-width constants for word and channel.
- Sub-module `bsg_link_credit_counter` holds the saturating up/down credit counter with decimated increment and the sticky overflow flag. The FSM and serializer stay in the top module.

## Test plan
- Reset, then release → `core_ready_o`=1, `link_valid_o`=0, `credit_count_o`=16, `error_o`=0.
- Accept 0x4444_3333_2222_1111 at cycle 0 → flits 0x1111, 0x2222, 0x3333, 0x4444 at cycles 1–4; credits 15. With the parity macro, parity is 0,0,0,0.
- 17 consecutive valid words, no tokens → 64 contiguous valid flits; `core_ready_o` low after the 16th accept; the 17th word is held.
- Credits 0, `token_i` pulse at cycle t → credits 4 and `core_ready_o`=1 at t+1; the held word is then sent.
- Credits 1, accept and `token_i` in the same cycle → credits 4 next cycle.
- Credits 16, `token_i` pulse → credits stay 16; `error_o`=1 and remains 1 until reset. Reset asserted at flit 2 of a word → `link_valid_o`=0 immediately, credits 16.

Source files
------------

// File: rtl/bsg_link_flit_pkg.sv
// bsg_link_flit_pkg: shared FSM state type and default word/channel widths for the flit link
package bsg_link_flit_pkg;
  typedef enum logic {IDLE, SEND} state_e;
  localparam int width_lp = 64;
  localparam int channel_width_lp = 16;
endpackage

// File: rtl/bsg_link_credit_counter.sv
// bsg_link_credit_counter: saturating credit counter (-1 per take, +2^lg per token) with sticky overflow error
module bsg_link_credit_counter #(
  parameter int credit_max_p = 16,
  parameter int lg_credit_decimation_p = 2,
  parameter int count_w_p = $clog2(credit_max_p + 1)
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 take,
  input  logic                 token,
  output logic [count_w_p-1:0] count,
  output logic                 error
);
  localparam int sum_w_lp = count_w_p + lg_credit_decimation_p + 1;
  localparam logic [sum_w_lp-1:0] max_lp = sum_w_lp'(credit_max_p);
  localparam logic [sum_w_lp-1:0] inc_lp = sum_w_lp'(1) << lg_credit_decimation_p;
  logic [sum_w_lp-1:0] sum;
  logic over;
  assign sum = sum_w_lp'(count) - sum_w_lp'(take) + (token ? inc_lp : '0);
  assign over = sum > max_lp;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= count_w_p'(credit_max_p);
      error <= 1'b0;
    end else begin
      count <= over ? count_w_p'(credit_max_p) : count_w_p'(sum);
      error <= error | over;
    end
endmodule

// File: rtl/bsg_link_flit_tx.sv
// bsg_link_flit_tx: credit-based word-to-flit serializer, LSB flit first; BSG_LINK_FLIT_TX_PARITY_EN adds even flit parity
module bsg_link_flit_tx
  import bsg_link_flit_pkg::*;
#(
  parameter int width_p = width_lp,
  parameter int channel_width_p = channel_width_lp,
  parameter int credit_max_p = 16,
  parameter int lg_credit_decimation_p = 2
)(
  input  logic                                 core_clk_i,
  input  logic                                 core_link_reset_i,
  input  logic [width_p-1:0]                   core_data_i,
  input  logic                                 core_valid_i,
  output logic                                 core_ready_o,
  output logic [channel_width_p-1:0]           link_data_o,
  output logic                                 link_valid_o,
  output logic                                 link_parity_o,
  input  logic                                 token_i,
  output logic [$clog2(credit_max_p+1)-1:0]    credit_count_o,
  output logic                                 error_o
);
  localparam int r_lp = width_p / channel_width_p;
  localparam int cnt_w_lp = r_lp > 1 ? $clog2(r_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(r_lp - 1);
  state_e state, state_n;
  logic [cnt_w_lp-1:0] cnt, cnt_n;
  logic [width_p-1:0] word;
  logic accept;
  assign core_ready_o = (state == IDLE || cnt == last_lp) && credit_count_o != '0;
  assign accept = core_valid_i & core_ready_o;
  always_comb begin
    state_n = accept ? SEND : (state == SEND && cnt != last_lp) ? SEND : IDLE;
    cnt_n = (accept || state == IDLE || cnt == last_lp) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge core_clk_i or posedge core_link_reset_i)
    if (core_link_reset_i) begin
      state <= IDLE;
      cnt <= '0;
      word <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) word <= core_data_i;
    end
  assign link_valid_o = state == SEND;
  assign link_data_o = link_valid_o ? word[cnt*channel_width_p +: channel_width_p] : '0;
`ifdef BSG_LINK_FLIT_TX_PARITY_EN
  assign link_parity_o = link_valid_o & (^link_data_o);
`else
  assign link_parity_o = 1'b0;
`endif
  bsg_link_credit_counter #(
    .credit_max_p(credit_max_p),
    .lg_credit_decimation_p(lg_credit_decimation_p)
  ) credits (
    .clk(core_clk_i),
    .rst(core_link_reset_i),
    .take(accept),
    .token(token_i),
    .count(credit_count_o),
    .error(error_o)
  );
endmodule

// File: tb/tb_bsg_link_flit_tx.sv
// tb_bsg_link_flit_tx: randomized and directed checks of the flit transmitter against a queue-based model
module tb_bsg_link_flit_tx;
  localparam int R = 4;
  logic clk = 0, rst = 1, core_valid = 0, token = 0;
  logic [63:0] core_data = '0;
  logic core_ready, link_valid, link_parity, error;
  logic [15:0] link_data;
  logic [4:0] credit_count;
  int checks = 0, fails = 0;
  logic [15:0] q[$];
  int m_cred = 16;
  bit m_err = 0;

  always #5 clk = ~clk;

  bsg_link_flit_tx dut (
    .core_clk_i(clk), .core_link_reset_i(rst), .core_data_i(core_data),
    .core_valid_i(core_valid), .core_ready_o(core_ready), .link_data_o(link_data),
    .link_valid_o(link_valid), .link_parity_o(link_parity), .token_i(token),
    .credit_count_o(credit_count), .error_o(error)
  );

  function automatic bit m_ready();
    return q.size() <= 1 && m_cred != 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit acc;
    int nc;
    if (rst) begin
      q.delete();
      m_cred = 16;
      m_err = 0;
    end else begin
      acc = core_valid && m_ready();
      if (q.size() > 0) void'(q.pop_front());
      if (acc) for (int k = 0; k < R; k++) q.push_back(core_data[k*16 +: 16]);
      nc = m_cred - int'(acc) + (token ? 4 : 0);
      if (nc > 16) begin
        nc = 16;
        m_err = 1;
      end
      m_cred = nc;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    logic [15:0] ed;
    bit ev, ep;
    ev = q.size() > 0;
    ed = ev ? q[0] : 16'h0;
`ifdef BSG_LINK_FLIT_TX_PARITY_EN
    ep = ev && (^ed);
`else
    ep = 0;
`endif
    chk("model_ready", core_ready, m_ready());
    chk("model_valid", link_valid, ev);
    chk("model_data", link_data, ed);
    chk("model_parity", link_parity, ep);
    chk("model_credits", credit_count, m_cred);
    chk("model_error", error, m_err);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    core_valid = 0;
    token = 0;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    int run, best, n;
    do_reset();
    chk("reset_ready", core_ready, 1);
    chk("reset_valid", link_valid, 0);
    chk("reset_credits", credit_count, 16);
    chk("reset_error", error, 0);
    chk("reset_parity", link_parity, 0);

    core_valid = 1;
    core_data = 64'h4444_3333_2222_1111;
    step();
    core_valid = 0;
    chk("word_credits", credit_count, 15);
    chk("flit0", link_data, 16'h1111);
    step();
    chk("flit1", link_data, 16'h2222);
    step();
    chk("flit2", link_data, 16'h3333);
    step();
    chk("flit3", link_data, 16'h4444);
    chk("flit3_valid", link_valid, 1);
    step();
    chk("word_done_valid", link_valid, 0);

    do_reset();
    core_valid = 1;
    core_data = {$urandom, $urandom};
    run = 0;
    best = 0;
    for (int c = 0; c < 75; c++) begin
      bit acc;
      acc = m_ready();
      step();
      if (acc) core_data = {$urandom, $urandom};
      run = link_valid ? run + 1 : 0;
      if (run > best) best = run;
    end
    chk("contig_flits", best, 64);
    chk("starved_credits", credit_count, 0);
    chk("starved_ready", core_ready, 0);
    chk("starved_valid", link_valid, 0);

    token = 1;
    step();
    token = 0;
    chk("token_credits", credit_count, 4);
    chk("token_ready", core_ready, 1);
    step();
    core_valid = 0;
    chk("held_sent", link_valid, 1);
    chk("held_credits", credit_count, 3);

    n = 0;
    while (m_cred > 1 && n < 200) begin
      core_valid = 1;
      if (m_ready()) core_data = {$urandom, $urandom};
      step();
      n++;
    end
    core_valid = 0;
    n = 0;
    while (!m_ready() && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("wait_ready_timeout", 1, 0);
    chk("one_credit", credit_count, 1);
    core_valid = 1;
    token = 1;
    core_data = {$urandom, $urandom};
    step();
    core_valid = 0;
    token = 0;
    chk("accept_and_token", credit_count, 4);
    repeat (4) step();

    do_reset();
    for (int c = 0; c < 600; c++) begin
      core_valid = $urandom_range(0, 9) < 7;
      token = $urandom_range(0, 19) == 0;
      core_data = {$urandom, $urandom};
      step();
    end
    core_valid = 0;
    token = 0;

    do_reset();
    token = 1;
    step();
    token = 0;
    chk("sat_credits", credit_count, 16);
    chk("sat_error", error, 1);
    repeat (3) step();
    chk("sticky_error", error, 1);

    core_valid = 1;
    core_data = 64'hdead_beef_cafe_f00d;
    step();
    core_valid = 0;
    step();
    step();
    chk("mid_flit2", link_data, 16'hbeef);
    rst = 1;
    #1;
    chk("async_valid", link_valid, 0);
    chk("async_credits", credit_count, 16);
    chk("async_error", error, 0);
    step();
    rst = 0;
    step();
    chk("post_reset_valid", link_valid, 0);
    chk("post_reset_ready", core_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
